// File: rtl/mycpu_mem.sv
// Memory stage of a simple pipelined CPU: turns EX bundles into SRAM-like
// requests and formats load results for writeback, one bundle in flight.
module mycpu_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rt_cont,
    input  logic [4:0]  ex_dest,
    input  logic        ex_reg_we,
    input  logic [2:0]  ex_mem_op,
    output logic        data_req,
    output logic        data_wr,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_dest,
    output logic        wb_reg_we,
    output logic        wb_exc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [2:0] OP_LW  = 3'b001;
    localparam logic [2:0] OP_LB  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;

    state_t      state, next_state;
    logic        accept;
    logic        is_mem, is_store, misalign, go_req;
    logic [2:0]  pend_op;
    logic [1:0]  pend_off;
    logic [7:0]  load_byte;
    logic [31:0] load_value;

    // Misaligned word accesses never reach the SRAM; they complete as exceptions.
    always_comb begin
        is_mem   = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        case (ex_mem_op)
            OP_LW: begin
                is_mem   = 1'b1;
                misalign = |ex_alu_result[1:0];
            end
            OP_SW: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                misalign = |ex_alu_result[1:0];
            end
            OP_LB, OP_LBU: is_mem = 1'b1;
            OP_SB: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            default: ;
        endcase
        go_req = is_mem & ~misalign;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        ex_ready   = 1'b0;
        data_req   = 1'b0;
        wb_valid   = 1'b0;
        case (state)
            IDLE: ex_ready = 1'b1;
            REQ: begin
                data_req = 1'b1;
                if (data_addr_ok)
                    next_state = WAIT;
            end
            WAIT: begin
                if (data_data_ok)
                    next_state = DONE;
            end
            DONE: begin
                wb_valid = 1'b1;
                ex_ready = wb_ready;
                if (wb_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        accept = ex_valid & ex_ready;
        if (accept)
            next_state = go_req ? REQ : DONE;
    end

    always_comb begin
        case (pend_off)
            2'd0:    load_byte = data_rdata[7:0];
            2'd1:    load_byte = data_rdata[15:8];
            2'd2:    load_byte = data_rdata[23:16];
            default: load_byte = data_rdata[31:24];
        endcase
        case (pend_op)
            OP_LB:   load_value = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_value = {24'd0, load_byte};
            default: load_value = data_rdata;
        endcase
    end

    // WB fields are written at accept time; loads overwrite the result when data returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_wr    <= 1'b0;
            data_addr  <= 32'd0;
            data_wstrb <= 4'd0;
            data_wdata <= 32'd0;
            wb_result  <= 32'd0;
            wb_dest    <= 5'd0;
            wb_reg_we  <= 1'b0;
            wb_exc     <= 1'b0;
            pend_op    <= 3'd0;
            pend_off   <= 2'd0;
        end else if (accept) begin
            wb_result <= ex_alu_result;
            wb_dest   <= ex_dest;
            wb_reg_we <= ex_reg_we & ~misalign & ~is_store;
            wb_exc    <= misalign;
            pend_op   <= ex_mem_op;
            pend_off  <= ex_alu_result[1:0];
            if (go_req) begin
                data_addr <= {ex_alu_result[31:2], 2'b00};
                data_wr   <= is_store;
                if (ex_mem_op == OP_SW) begin
                    data_wstrb <= 4'b1111;
                    data_wdata <= ex_rt_cont;
                end else if (ex_mem_op == OP_SB) begin
                    data_wstrb <= 4'b0001 << ex_alu_result[1:0];
                    data_wdata <= {4{ex_rt_cont[7:0]}};
                end else begin
                    data_wstrb <= 4'b0000;
                    data_wdata <= 32'd0;
                end
            end
        end else if (state == WAIT && data_data_ok) begin
            if (pend_op == OP_LW || pend_op == OP_LB || pend_op == OP_LBU)
                wb_result <= load_value;
        end
    end

endmodule

// File: tb/tb_mycpu_mem.sv
// Self-checking bench for mycpu_mem: scenario tasks drive EX bundles and a
// hand-timed SRAM, expected WB bundles flow through a scoreboard queue.
module tb_mycpu_mem;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_LB   = 3'b010;
    localparam logic [2:0] OP_LBU  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_SB   = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rt_cont;
    logic [4:0]  ex_dest;
    logic        ex_reg_we;
    logic [2:0]  ex_mem_op;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_result;
    logic [4:0]  wb_dest;
    logic        wb_reg_we;
    logic        wb_exc;

    // Scoreboard entry: {result, dest, reg_we, exc}
    logic [38:0] sb_q[$];
    logic [38:0] exp_wb;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] result;
        logic        we;
    } mem_case_t;

    mycpu_mem dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_rt_cont(ex_rt_cont),
        .ex_dest(ex_dest), .ex_reg_we(ex_reg_we), .ex_mem_op(ex_mem_op),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
        .wb_dest(wb_dest), .wb_reg_we(wb_reg_we), .wb_exc(wb_exc)
    );

    always #5 clk = ~clk;

    task automatic drive_ex(input logic [2:0] op, input logic [31:0] alu,
                            input logic [31:0] rt, input logic [4:0] dest,
                            input logic we);
        ex_valid      = 1'b1;
        ex_mem_op     = op;
        ex_alu_result = alu;
        ex_rt_cont    = rt;
        ex_dest       = dest;
        ex_reg_we     = we;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({wb_valid, data_req, data_wr, data_wstrb, wb_exc, wb_reg_we} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000000",
                     {wb_valid, data_req, data_wr, data_wstrb, wb_exc, wb_reg_we});
        end
        checks++;
        if (data_addr !== 32'd0 || data_wdata !== 32'd0 || wb_result !== 32'd0 || wb_dest !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: got addr=%h wdata=%h result=%h dest=%0d expected all 0",
                     data_addr, data_wdata, wb_result, wb_dest);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ex_ready: got %b expected 1", ex_ready);
        end
    endtask

    task automatic test_none_stream();
        logic we;
        wb_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_wb = sb_q.pop_front();
                checks++;
                if (wb_valid !== 1'b1 || {wb_result, wb_dest, wb_reg_we, wb_exc} !== exp_wb) begin
                    errors++;
                    $display("[TB] FAIL none_wb%0d: got valid=%b %h expected valid=1 %h", i,
                             wb_valid, {wb_result, wb_dest, wb_reg_we, wb_exc}, exp_wb);
                end
            end
            if (i < 4) begin
                we = (i != 2);
                drive_ex(OP_NONE, 32'h1234 + 32'(i), 32'hFFFF0000, 5'(3 + i), we);
                sb_q.push_back({32'h1234 + 32'(i), 5'(3 + i), we, 1'b0});
                #1;
                checks++;
                if (ex_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL none_ex_ready%0d: got %b expected 1", i, ex_ready);
                end
            end else begin
                ex_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL none_idle: got wb_valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_mem_ops();
        mem_case_t tbl[9];
        tbl[0] = '{OP_LB,  32'h102, 32'h0,        32'h0080FF00, 32'h100, 1'b0, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b1};
        tbl[1] = '{OP_LBU, 32'h102, 32'h0,        32'h0080FF00, 32'h100, 1'b0, 4'b0000, 32'h0,        32'h00000080, 1'b1};
        tbl[2] = '{OP_LB,  32'h101, 32'h0,        32'h0080FF00, 32'h100, 1'b0, 4'b0000, 32'h0,        32'hFFFFFFFF, 1'b1};
        tbl[3] = '{OP_LBU, 32'h100, 32'h0,        32'h0080FF00, 32'h100, 1'b0, 4'b0000, 32'h0,        32'h00000000, 1'b1};
        tbl[4] = '{OP_LW,  32'h104, 32'h0,        32'h11223344, 32'h104, 1'b0, 4'b0000, 32'h0,        32'h11223344, 1'b1};
        tbl[5] = '{OP_SB,  32'h203, 32'hAB,       32'h0,        32'h200, 1'b1, 4'b1000, 32'hABABABAB, 32'h00000203, 1'b0};
        tbl[6] = '{OP_SW,  32'h40,  32'hDEADBEEF, 32'h0,        32'h040, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h00000040, 1'b0};
        tbl[7] = '{OP_SB,  32'h0,   32'h12345678, 32'h0,        32'h000, 1'b1, 4'b0001, 32'h78787878, 32'h00000000, 1'b0};
        tbl[8] = '{OP_LB,  32'h103, 32'h0,        32'h7F000000, 32'h100, 1'b0, 4'b0000, 32'h0,        32'h0000007F, 1'b1};
        wb_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            drive_ex(tbl[n].op, tbl[n].alu, tbl[n].rt, 5'(10 + n), 1'b1);
            sb_q.push_back({tbl[n].result, 5'(10 + n), tbl[n].we, 1'b0});
            data_rdata = 32'hDEADDEAD;
            @(negedge clk);
            ex_valid = 1'b0;
            // Two cycles of addr_ok low, then accept on the third.
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({data_req, data_wr, data_addr, data_wstrb} !== {1'b1, tbl[n].wr, tbl[n].addr, tbl[n].wstrb}) begin
                    errors++;
                    $display("[TB] FAIL mem%0d_req%0d: got req=%b wr=%b addr=%h wstrb=%b expected 1 %b %h %b",
                             n, k, data_req, data_wr, data_addr, data_wstrb,
                             tbl[n].wr, tbl[n].addr, tbl[n].wstrb);
                end
                if (tbl[n].wr) begin
                    checks++;
                    if (data_wdata !== tbl[n].wdata) begin
                        errors++;
                        $display("[TB] FAIL mem%0d_wdata%0d: got %h expected %h", n, k, data_wdata, tbl[n].wdata);
                    end
                end
                if (k == 2) data_addr_ok = 1'b1;
                @(negedge clk);
            end
            data_addr_ok = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (k == 0) begin
                    checks++;
                    if (data_req !== 1'b0 || wb_valid !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL mem%0d_wait: got req=%b wb_valid=%b expected 0 0", n, data_req, wb_valid);
                    end
                end
                if (k == 2) begin
                    data_data_ok = 1'b1;
                    data_rdata   = tbl[n].rdata;
                end
                @(negedge clk);
            end
            data_data_ok = 1'b0;
            data_rdata   = 32'hBAD0BAD0;
            exp_wb = sb_q.pop_front();
            checks++;
            if (wb_valid !== 1'b1 || {wb_result, wb_dest, wb_reg_we, wb_exc} !== exp_wb) begin
                errors++;
                $display("[TB] FAIL mem%0d_wb: got valid=%b %h expected valid=1 %h", n,
                         wb_valid, {wb_result, wb_dest, wb_reg_we, wb_exc}, exp_wb);
            end
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  ops[4]  = '{OP_LW, OP_SW, 3'b110, 3'b111};
        logic [31:0] alus[4] = '{32'h6, 32'h11, 32'h55, 32'h77};
        logic        exps[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        wes[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        in_we[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        wb_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            drive_ex(ops[n], alus[n], 32'h5A5A5A5A, 5'(20 + n), in_we[n]);
            sb_q.push_back({alus[n], 5'(20 + n), wes[n], exps[n]});
            @(negedge clk);
            ex_valid = 1'b0;
            checks++;
            if (data_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL misalign%0d_req: got %b expected 0", n, data_req);
            end
            exp_wb = sb_q.pop_front();
            checks++;
            if (wb_valid !== 1'b1 || {wb_result, wb_dest, wb_reg_we, wb_exc} !== exp_wb) begin
                errors++;
                $display("[TB] FAIL misalign%0d_wb: got valid=%b %h expected valid=1 %h", n,
                         wb_valid, {wb_result, wb_dest, wb_reg_we, wb_exc}, exp_wb);
            end
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        wb_ready = 1'b0;
        drive_ex(OP_NONE, 32'hCAFE0001, 32'h0, 5'd7, 1'b1);
        sb_q.push_back({32'hCAFE0001, 5'd7, 1'b1, 1'b0});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_ex(OP_NONE, 32'hCAFE0002, 32'h0, 5'd8, 1'b0);
            #1;
            checks++;
            if (wb_valid !== 1'b1 || {wb_result, wb_dest, wb_reg_we, wb_exc} !== sb_q[0]) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got valid=%b %h expected valid=1 %h", k,
                         wb_valid, {wb_result, wb_dest, wb_reg_we, wb_exc}, sb_q[0]);
            end
            checks++;
            if (ex_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_ex_ready%0d: got %b expected 0", k, ex_ready);
            end
        end
        @(negedge clk);
        wb_ready = 1'b1;
        #1;
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release_ready: got %b expected 1", ex_ready);
        end
        exp_wb = sb_q.pop_front();
        checks++;
        if (wb_valid !== 1'b1 || {wb_result, wb_dest, wb_reg_we, wb_exc} !== exp_wb) begin
            errors++;
            $display("[TB] FAIL stall_first: got valid=%b %h expected valid=1 %h",
                     wb_valid, {wb_result, wb_dest, wb_reg_we, wb_exc}, exp_wb);
        end
        sb_q.push_back({32'hCAFE0002, 5'd8, 1'b0, 1'b0});
        @(negedge clk);
        ex_valid = 1'b0;
        exp_wb = sb_q.pop_front();
        checks++;
        if (wb_valid !== 1'b1 || {wb_result, wb_dest, wb_reg_we, wb_exc} !== exp_wb) begin
            errors++;
            $display("[TB] FAIL stall_second: got valid=%b %h expected valid=1 %h",
                     wb_valid, {wb_result, wb_dest, wb_reg_we, wb_exc}, exp_wb);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_idle: got wb_valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_reset_wait();
        wb_ready = 1'b1;
        @(negedge clk);
        drive_ex(OP_LW, 32'h100, 32'h0, 5'd9, 1'b1);
        @(negedge clk);
        ex_valid     = 1'b0;
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        checks++;
        if (data_req !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstwait_pre: got req=%b wb_valid=%b expected 0 0", data_req, wb_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (data_addr !== 32'd0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstwait_async: got addr=%h wb_valid=%b ex_ready=%b expected 0 0 1",
                     data_addr, wb_valid, ex_ready);
        end
        @(negedge clk);
        reset        = 1'b0;
        data_data_ok = 1'b1;
        data_addr_ok = 1'b1;
        data_rdata   = 32'h99999999;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            data_data_ok = 1'b0;
            data_addr_ok = 1'b0;
            checks++;
            if (wb_valid !== 1'b0 || data_req !== 1'b0 || ex_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rstwait_late%0d: got wb_valid=%b req=%b ex_ready=%b expected 0 0 1",
                         k, wb_valid, data_req, ex_ready);
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
    endtask

    initial begin
        reset         = 1'b1;
        ex_valid      = 1'b0;
        ex_mem_op     = 3'd0;
        ex_alu_result = 32'd0;
        ex_rt_cont    = 32'd0;
        ex_dest       = 5'd0;
        ex_reg_we     = 1'b0;
        data_addr_ok  = 1'b0;
        data_data_ok  = 1'b0;
        data_rdata    = 32'd0;
        wb_ready      = 1'b1;
        test_reset();
        test_none_stream();
        test_mem_ops();
        test_misalign();
        test_stall();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mycpu_mem.md
MYCPU_MEM -- requirements
Module: mycpu_mem

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ex_valid  in  1  EX bundle valid.
REQ-005 ex_ready  out  1  stage can accept an EX bundle this cycle.
REQ-006 ex_alu_result  in  32  ALU result: byte address for memory ops, result otherwise.
REQ-007 ex_rt_cont  in  32  store data.
REQ-008 ex_dest  in  5  destination register.
REQ-009 ex_reg_we  in  1  register write enable.
REQ-010 ex_mem_op  in  3  000 NONE, 001 LW, 010 LB, 011 LBU, 100 SW, 101 SB; 110/111 treated as NONE.
REQ-011 data_req  out  1  SRAM request valid.
REQ-012 data_wr  out  1  1 = write, 0 = read.
REQ-013 data_addr  out  32  word-aligned address, {alu[31:2],2'b00}.
REQ-014 data_wstrb  out  4  byte write strobes; 0000 on reads.
REQ-015 data_wdata  out  32  write data.
REQ-016 data_addr_ok  in  1  SRAM accepted request.
REQ-017 data_data_ok  in  1  read data valid or write complete; never in the same cycle as its own addr_ok.
REQ-018 data_rdata  in  32  read data.
REQ-019 wb_valid  out  1  WB bundle valid.
REQ-020 wb_ready  in  1  WB accepts bundle.
REQ-021 wb_result  out  32  result, load data, or faulting address.
REQ-022 wb_dest  out  5  destination register.
REQ-023 wb_reg_we  out  1  register write enable.
REQ-024 wb_exc  out  1  address-misalignment exception flag.

Function
REQ-025 FSM states: IDLE, REQ, WAIT, DONE; one bundle in flight at most.
REQ-026 ex_ready = (state==IDLE) | (state==DONE & wb_ready); a bundle is accepted when ex_valid & ex_ready.
REQ-027 Accept of NONE -> DONE next cycle; wb_result = alu_result; wb_reg_we = ex_reg_we; latency 1.
REQ-028 Accept of an aligned load/store -> REQ.
REQ-029 REQ: data_req=1; addr, wr, wstrb, and wdata held stable until data_addr_ok; on addr_ok -> WAIT.
REQ-030 WAIT: data_req=0; on data_data_ok -> DONE, capturing data_rdata on the same edge.
REQ-031 DONE: wb_valid=1 with fields stable until wb_ready; wb_ready with no new accept -> IDLE.
REQ-032 DONE with wb_ready and a new accept in the same cycle: the new bundle is taken and DONE -> DONE/REQ per op, so a NONE stream runs at 1 per cycle.
REQ-033 LW: wb_result = rdata.
REQ-034 LB: byte rdata[8*a+7:8*a] (a = addr[1:0]), sign-extended.
REQ-035 LBU: the same byte, zero-extended.
REQ-036 SW: wstrb = 1111; wdata = rt.
REQ-037 SB: wstrb = 0001<<a; wdata = {4{rt[7:0]}}.
REQ-038 Stores: wb_reg_we = 0; wb_result = alu_result.
REQ-039 LW/SW with addr[1:0]!=0: no SRAM request; -> DONE; wb_exc=1, wb_reg_we=0, wb_result = byte address.
REQ-040 wb_exc = 0 for all other bundles.
REQ-041 data_data_ok or data_addr_ok outside REQ/WAIT as appropriate is ignored.

Reset
REQ-042 reset asserted asynchronously forces IDLE with wb_valid=0, data_req=0, data_wr=0, data_wstrb=0, wb_exc=0, wb_reg_we=0, and all data/address outputs 0.
REQ-043 reset during REQ/WAIT abandons the transaction; a late data_data_ok after reset is ignored.
REQ-044 ex_ready = 1 in the first cycle after reset deassertion.

Verification
REQ-045 NONE, alu=0x1234, dest=3, reg_we=1; wb_ready=1 -> wb_valid the next cycle with result 0x1234, dest 3, we 1; back-to-back NONEs at 1 per cycle.
REQ-046 LB, addr 0x102; SRAM addr_ok after 2 cycles and data_ok 3 cycles later with rdata 0x0080FF00 -> data_addr 0x100 held, wstrb 0000, wb_result 0xFFFFFF80; LBU -> 0x00000080.
REQ-047 SB, addr 0x203, rt 0xAB -> data_wr 1, wstrb 1000, wdata 0xABABABAB; wb_reg_we 0 after data_ok.
REQ-048 LW, addr 0x6 -> data_req stays 0; wb_exc 1, wb_result 0x6, wb_reg_we 0.
REQ-049 wb_ready held 0 for 4 cycles in DONE -> WB fields stable and ex_ready 0.
REQ-050 reset pulse in WAIT, then data_ok -> IDLE; no wb_valid.
